// File: rtl/score_hex_display_if.sv
// score_hex_display_if
// Bundles the load strobe, value bus, status flags and six segment outputs of
// the score_hex_display driver. The master side (game logic / bench) drives
// value_i and load_i; the slave side (the display driver) drives the rest.
interface score_hex_display_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] value_i;
    logic             load_i;
    logic             busy_o;
    logic             done_o;
    logic             overflow_o;
    logic [6:0]       hex0_o;
    logic [6:0]       hex1_o;
    logic [6:0]       hex2_o;
    logic [6:0]       hex3_o;
    logic [6:0]       hex4_o;
    logic [6:0]       hex5_o;

    modport master (
        output value_i, load_i,
        input  busy_o, done_o, overflow_o,
        input  hex0_o, hex1_o, hex2_o, hex3_o, hex4_o, hex5_o
    );

    modport slave (
        input  value_i, load_i,
        output busy_o, done_o, overflow_o,
        output hex0_o, hex1_o, hex2_o, hex3_o, hex4_o, hex5_o
    );
endinterface

// File: rtl/score_hex_display.sv
// score_hex_display
// Sequential binary-to-7-segment driver for six HEX displays. A load strobe
// captures a (saturated) value, a double-dabble engine shifts it into six BCD
// digits over WIDTH cycles, and a final ENCODE cycle updates all segment
// outputs at once so the displays never show intermediate digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> digits above the most significant non-zero digit are blank
//                (hex0 always shows a digit)
//   undefined -> all six digits shown, including leading zeros
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for load_i; outputs hold the last completed conversion
// SHIFT  | one add-3/shift step per cycle, WIDTH steps in total
// ENCODE | segment patterns and overflow flag registered, done_o pulses
module score_hex_display #(
    parameter int WIDTH     = 20,
    parameter int SAT_VALUE = 999999
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    score_hex_display_if.slave  bus
);

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
    localparam logic [31:0] SAT_U     = 32'(SAT_VALUE);
    localparam logic [4:0]  CNT_INIT  = 5'(WIDTH);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0]  HEX_HI_RST = SEG_BLANK;
`else
    localparam logic [6:0]  HEX_HI_RST = SEG_ZERO;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_capture;
    logic             w_shift;
    logic             w_encode;

    logic [WIDTH-1:0] r_bin;
    logic [23:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic             r_ovf_pend;

    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [6:0]       r_hex [6];

    logic             w_over;
    logic [WIDTH-1:0] w_sat_val;
    logic [23:0]      w_bcd_adj;
    logic [6:0]       w_hex_nxt [6];
    logic             w_lead_zero;

    // Active-low 7-segment pattern (bit6=g ... bit0=a) for one BCD digit.
    function automatic logic [6:0] f_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Saturate the incoming value; SAT_VALUE always fits in WIDTH bits when it
    // can actually be exceeded, so truncating it is safe in that case.
    always_comb begin
        w_over    = 32'(bus.value_i) > SAT_U;
        w_sat_val = w_over ? SAT_U[WIDTH-1:0] : bus.value_i;
    end

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        w_encode    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == 5'd1) begin
                    w_state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                w_encode    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more before shifting.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 6; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Segment patterns for the finished BCD value, with optional blanking of
    // leading zeros scanning down from the top digit.
    always_comb begin
        w_lead_zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_hex_nxt[i] = f_seg(r_bcd[i*4 +: 4]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 5; i >= 1; i--) begin
            w_lead_zero = w_lead_zero & (r_bcd[i*4 +: 4] == 4'd0);
            if (w_lead_zero) begin
                w_hex_nxt[i] = SEG_BLANK;
            end
        end
`else
        w_lead_zero = 1'b0;
`endif
    end

    // Conversion engine: capture, shift, count.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_capture) begin
            r_bin      <= w_sat_val;
            r_bcd      <= '0;
            r_cnt      <= CNT_INIT;
            r_ovf_pend <= w_over;
        end else if (w_shift) begin
            r_bcd      <= {w_bcd_adj[22:0], r_bin[WIDTH-1]};
            r_bin      <= r_bin << 1;
            r_cnt      <= r_cnt - 5'd1;
        end
    end

    // Output registers: only the ENCODE cycle or reset changes the displays.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_hex[0] <= SEG_ZERO;
            for (int i = 1; i < 6; i++) begin
                r_hex[i] <= HEX_HI_RST;
            end
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_encode;
            if (w_encode) begin
                r_ovf <= r_ovf_pend;
                for (int i = 0; i < 6; i++) begin
                    r_hex[i] <= w_hex_nxt[i];
                end
            end
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.overflow_o = r_ovf;
    assign bus.hex0_o     = r_hex[0];
    assign bus.hex1_o     = r_hex[1];
    assign bus.hex2_o     = r_hex[2];
    assign bus.hex3_o     = r_hex[3];
    assign bus.hex4_o     = r_hex[4];
    assign bus.hex5_o     = r_hex[5];

endmodule

// File: tb/tb_score_hex_display.sv
// tb_score_hex_display
// Directed bench for score_hex_display: a vector table of values with their
// expected displayed number and overflow flag, plus hand-written sequences for
// ignored loads, mid-conversion reset and back-to-back conversions.
module tb_score_hex_display;

    localparam int WIDTH = 20;
    localparam int LAT   = WIDTH + 1;

    logic clk_clk;
    logic reset_reset;
    int   checks;
    int   errors;

    score_hex_display_if #(.WIDTH(WIDTH)) bus ();

    score_hex_display #(.WIDTH(WIDTH), .SAT_VALUE(999999)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    logic [6:0] hx [6];
    assign hx[0] = bus.hex0_o;
    assign hx[1] = bus.hex1_o;
    assign hx[2] = bus.hex2_o;
    assign hx[3] = bus.hex3_o;
    assign hx[4] = bus.hex4_o;
    assign hx[5] = bus.hex5_o;

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    typedef struct {
        logic [19:0] val;
        int          disp;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p) return 7'b1111111;
`endif
        return seg_of((v / p) % 10);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_display(input string name, input int v);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s hex%0d", name, i), int'(hx[i]), int'(exp_seg(v, i)));
        end
    endtask

    // Drive one load strobe so that it is sampled at the next rising edge.
    task automatic pulse_load(input logic [19:0] v);
        @(negedge clk_clk);
        bus.value_i = v;
        bus.load_i  = 1'b1;
        @(posedge clk_clk);
        #1;
        bus.load_i  = 1'b0;
    endtask

    initial begin
        int lat;
        int dones;
        int last_done;
        int prev_disp;
        logic held_ok;
        logic [6:0] hold_hex0;

        checks = 0;
        errors = 0;
        bus.value_i = '0;
        bus.load_i  = 1'b0;
        reset_reset = 1'b1;

        vecs[0] = '{val: 20'd123456,  disp: 123456, ovf: 1'b0};
        vecs[1] = '{val: 20'hFFFFF,   disp: 999999, ovf: 1'b1};
        vecs[2] = '{val: 20'd0,       disp: 0,      ovf: 1'b0};
        vecs[3] = '{val: 20'd999999,  disp: 999999, ovf: 1'b0};
        vecs[4] = '{val: 20'd1000000, disp: 999999, ovf: 1'b1};
        vecs[5] = '{val: 20'd42,      disp: 42,     ovf: 1'b0};
        vecs[6] = '{val: 20'd100005,  disp: 100005, ovf: 1'b0};
        vecs[7] = '{val: 20'd7,       disp: 7,      ovf: 1'b0};
        vecs[8] = '{val: 20'd908070,  disp: 908070, ovf: 1'b0};

        // Reset then idle.
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (5) @(posedge clk_clk);
        #1;
        check("reset busy", int'(bus.busy_o), 0);
        check("reset done", int'(bus.done_o), 0);
        check("reset ovf",  int'(bus.overflow_o), 0);
        check_display("reset", 0);

        // Table-driven conversions.
        prev_disp = 0;
        for (int n = 0; n < 9; n++) begin
            pulse_load(vecs[n].val);
            check($sformatf("v%0d busy after load", n), int'(bus.busy_o), 1);
            lat = 0;
            held_ok = 1'b1;
            hold_hex0 = hx[0];
            for (int k = 1; k <= LAT + 10; k++) begin
                @(posedge clk_clk);
                #1;
                if (bus.done_o) begin
                    lat = k;
                    break;
                end
                if (hx[0] !== hold_hex0 || hx[5] !== exp_seg(prev_disp, 5)) held_ok = 1'b0;
            end
            check($sformatf("v%0d latency", n), lat, LAT);
            check($sformatf("v%0d hold during conv", n), int'(held_ok), 1);
            check($sformatf("v%0d busy at done", n), int'(bus.busy_o), 0);
            check($sformatf("v%0d ovf", n), int'(bus.overflow_o), int'(vecs[n].ovf));
            check_display($sformatf("v%0d", n), vecs[n].disp);
            @(posedge clk_clk);
            #1;
            check($sformatf("v%0d done one cycle", n), int'(bus.done_o), 0);
            prev_disp = vecs[n].disp;
        end

        // Load 42, then a second strobe with 7 at cycle 5 must be ignored.
        pulse_load(20'd42);
        dones = 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                bus.value_i = 20'd7;
                bus.load_i  = 1'b1;
            end
            @(posedge clk_clk);
            #1;
            if (k == 5) bus.load_i = 1'b0;
            if (bus.done_o) begin
                dones++;
                if (lat == 0) begin
                    lat = k;
                    check_display("ignored load", 42);
                end
            end
        end
        check("ignored load dones", dones, 1);
        check("ignored load latency", lat, LAT);
        check("ignored load idle", int'(bus.busy_o), 0);

        // Load 555555, reset at cycle 10: conversion discarded.
        pulse_load(20'd555555);
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk_clk);
            #1;
            if (bus.done_o) dones++;
        end
        @(negedge clk_clk);
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        check("abort busy", int'(bus.busy_o), 0);
        check("abort done", int'(bus.done_o), 0);
        check("abort ovf",  int'(bus.overflow_o), 0);
        check_display("abort", 0);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_clk);
            #1;
            if (bus.done_o) dones++;
        end
        check("abort no done", dones, 0);
        check("abort display kept", int'(hx[0]), int'(exp_seg(0, 0)));

        // Load held high with value 9: back-to-back conversions every LAT+1.
        @(negedge clk_clk);
        bus.value_i = 20'd9;
        bus.load_i  = 1'b1;
        dones = 0;
        last_done = -1;
        for (int k = 0; k < 4 * (LAT + 1); k++) begin
            @(posedge clk_clk);
            #1;
            if (bus.done_o) begin
                dones++;
                if (last_done < 0) check("b2b first done", k, LAT);
                else check("b2b spacing", k - last_done, LAT + 1);
                check("b2b hex0", int'(hx[0]), int'(7'b0010000));
                last_done = k;
            end
        end
        check("b2b done count", dones, 4);
        @(negedge clk_clk);
        bus.load_i = 1'b0;
        lat = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            @(posedge clk_clk);
            #1;
            if (!bus.busy_o) begin
                lat = 1;
                break;
            end
        end
        check("b2b returns idle", lat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
